// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

   localparam int          RV_XLEN   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

   typedef struct packed {
      logic [RV_XLEN-1:0] pc;
      logic [31:0]        instr;
      logic               filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch buffer: slots are allocated at request, filled at response, popped at consume
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic [RV_XLEN-1:0] alloc_pc_i,
   input  logic               fill_i,
   input  logic [31:0]        fill_instr_i,
   input  logic               pop_i,
   output logic               head_valid_o,
   output logic [RV_XLEN-1:0] head_pc_o,
   output logic [31:0]        head_instr_o,
   output logic [CW-1:0]      count_o,
   output logic [CW-1:0]      unfilled_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  slots_q [DEPTH];
   logic [AW-1:0] alloc_ptr_q;
   logic [AW-1:0] fill_ptr_q;
   logic [AW-1:0] pop_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] unfilled_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
         end
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         pop_ptr_q   <= '0;
         count_q     <= '0;
         unfilled_q  <= '0;
      end else if (flush_i) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         pop_ptr_q   <= '0;
         count_q     <= '0;
         unfilled_q  <= '0;
      end else begin
         if (alloc_i) begin
            slots_q[alloc_ptr_q] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
            alloc_ptr_q          <= alloc_ptr_q + 1'b1;
         end
         if (fill_i) begin
            slots_q[fill_ptr_q].instr  <= fill_instr_i;
            slots_q[fill_ptr_q].filled <= 1'b1;
            fill_ptr_q                 <= fill_ptr_q + 1'b1;
         end
         if (pop_i) begin
            pop_ptr_q <= pop_ptr_q + 1'b1;
         end
         count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
         unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
      end
   end

   assign head_valid_o = (count_q != '0) && slots_q[pop_ptr_q].filled;
   assign head_pc_o    = slots_q[pop_ptr_q].pc;
   assign head_instr_o = slots_q[pop_ptr_q].instr;
   assign count_o      = count_q;
   assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch: PC, imem handshake, redirect flush
// Define FETCH_STATS_EN to add the stat_fetched / stat_bubble counters.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = RV_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     stat_fetched,
   output logic [31:0]     stat_bubble
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   q_count, q_unfilled;
   logic            head_valid;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic            consume, accept, rsp_fill;

   assign consume  = head_valid && !stall;
   assign accept   = imem_req_valid && imem_req_ready;
   assign rsp_fill = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

   // Requests in flight that will be dropped still hold a credit until their response returns.
   assign imem_req_valid = rst && (((int'(q_count) + int'(drop_q)) < DEPTH) || consume);
   assign imem_req_addr  = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~XLEN'(3);
         drop_d     = drop_q + q_unfilled + CW'(accept) - CW'(imem_rsp_valid);
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect_valid),
      .alloc_i      (accept && !redirect_valid),
      .alloc_pc_i   (fetch_pc_q),
      .fill_i       (rsp_fill),
      .fill_instr_i (imem_rsp_data),
      .pop_i        (consume && !redirect_valid),
      .head_valid_o (head_valid),
      .head_pc_o    (head_pc),
      .head_instr_o (head_instr),
      .count_o      (q_count),
      .unfilled_o   (q_unfilled)
   );

   assign if_valid = head_valid;
   assign if_pc    = head_valid ? head_pc : '0;
   assign if_instr = head_valid ? head_instr : NOP_INSTR;

`ifdef FETCH_STATS_EN
   logic [31:0] fetched_q, bubble_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= '0;
         bubble_q  <= '0;
      end else if (!redirect_valid) begin
         if (consume) begin
            fetched_q <= fetched_q + 32'd1;
         end
         if (!head_valid && !stall) begin
            bubble_q <= bubble_q + 32'd1;
         end
      end
   end

   assign stat_fetched = fetched_q;
   assign stat_bubble  = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an architectural PC-stream model
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk            = 1'b0;
   logic        rst            = 1'b0;
   logic        stall          = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int consumed = 0;
   int p_stall = 0, p_ready = 100, p_redir = 0, dly_min = 1, dly_max = 1;
   logic        rel_pending = 1'b0;
   logic        force_redir = 1'b0;
   logic [31:0] force_pc    = '0;

   // memory model: accepted addresses with the cycle their response is due
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   // architectural expectations
   logic [31:0] exp_if_pc  = RESET_PC;
   logic [31:0] exp_req_pc = RESET_PC;
   logic [31:0] prev_pc    = '0;
   logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_redirect = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, NOP_INSTR);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      stall = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      exp_if_pc = RESET_PC; exp_req_pc = RESET_PC;
      prev_valid = 1'b0; prev_stall = 1'b0; prev_redirect = 1'b0; prev_pc = '0;
      cyc = 0;
      rel_pending = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic step();
      logic acc;
      @(posedge clk);
      #1;
      cyc++;
      if (rel_pending) begin
         rst = 1'b1;
         rel_pending = 1'b0;
      end
      stall          = ($urandom_range(99) < p_stall);
      imem_req_ready = ($urandom_range(99) < p_ready);
      redirect_valid = force_redir || ($urandom_range(99) < p_redir);
      redirect_pc    = force_redir ? force_pc : ($urandom() & 32'h0000_0fff);
      force_redir    = 1'b0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom();
      end

      @(negedge clk);
      if (!if_valid) chk("nop_on_bubble", if_instr, NOP_INSTR);
      if (prev_redirect) chk("bubble_after_redirect", if_valid, 0);
      if (prev_valid && prev_stall && !prev_redirect) begin
         chk("stall_hold_valid", if_valid, 1);
         chk("stall_hold_pc", if_pc, prev_pc);
      end
      if (if_valid) begin
         chk("if_pc", if_pc, exp_if_pc);
         chk("if_instr", if_instr, mem_word(if_pc));
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);

      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
      end
      chk("outstanding_bound", mq_addr.size() <= DEPTH, 1);

      if (redirect_valid) begin
         exp_if_pc  = {redirect_pc[31:2], 2'b00};
         exp_req_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (if_valid && !stall) begin
            exp_if_pc = exp_if_pc + 32'd4;
            consumed++;
         end
         if (acc) exp_req_pc = exp_req_pc + 32'd4;
      end
      prev_valid    = if_valid;
      prev_stall    = stall;
      prev_redirect = redirect_valid;
      prev_pc       = if_pc;
   endtask

   initial begin
      logic [31:0] a0;
      int          nvalid;
      int          lat;
      bit          seen;

      do_reset();

      // streaming from reset with 1-cycle memory
      step(); chk("c1_bubble", if_valid, 0); chk("c1_req_valid", imem_req_valid, 1);
      step(); chk("c2_bubble", if_valid, 0);
      step(); chk("c3_valid", if_valid, 1); chk("c3_pc", if_pc, 32'h0);
      step(); chk("c4_pc", if_pc, 32'h4);
      p_stall = 100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stalled_pc", if_pc, 32'h8);
      end
      p_stall = 0;
      step(); chk("resume_pc8", if_pc, 32'h8);
      step(); chk("resume_pcC", if_pc, 32'hC);
      step(); chk("resume_pc10", if_pc, 32'h10);
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (if_valid) nvalid++;
      end
      chk("throughput", nvalid, 10);

      // memory not ready for 4 cycles
      p_ready = 0;
      step(); a0 = imem_req_addr; chk("ready_low_req_valid", imem_req_valid, 1);
      repeat (3) step();
      chk("ready_low_addr", imem_req_addr, a0);
      p_ready = 100;
      repeat (6) step();

      // redirect coinciding with a response and an accept
      force_redir = 1'b1; force_pc = 32'h200;
      step();
      chk("combo_setup", {imem_rsp_valid, imem_req_valid && imem_req_ready}, 2'b11);
      seen = 0; lat = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         step();
         if (if_valid) begin seen = 1; lat = i; end
      end
      chk("combo_seen", seen, 1);
      chk("combo_pc", if_pc, 32'h200);
      chk("combo_latency", lat, 3);

      // redirect to an unaligned target with slow memory
      dly_min = 3; dly_max = 3;
      repeat (8) step();
      force_redir = 1'b1; force_pc = 32'h103;
      step();
      seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         step();
         if (if_valid) seen = 1;
      end
      chk("redir_seen", seen, 1);
      chk("redir_pc", if_pc, 32'h100);

      // reset mid-stream restarts at RESET_PC
      dly_min = 1; dly_max = 1;
      do_reset();
      repeat (3) step();
      chk("restart_valid", if_valid, 1);
      chk("restart_pc", if_pc, RESET_PC);

      // randomized traffic
      p_stall = 25; p_ready = 70; p_redir = 4; dly_min = 1; dly_max = 4;
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) < 3) do_reset();
         step();
      end
      chk("liveness", consumed > 200, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V pipeline. It owns the PC and issues in-order requests to instruction memory over a valid/ready handshake. Responses land in a small in-order queue, and the unit presents one {pc, instr} per cycle to the IF/ID pipeline register. It obeys the hazard unit's stall and the EX stage's branch/jump redirect, discarding any wrong-path instructions still in flight.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, queue slots (power of two, ≥2); bounds outstanding plus buffered instructions

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  IF/ID hold from hazard unit; the head entry is not consumed
- redirect_valid  in  1  branch/jump taken or resolved in EX; flush and refetch
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 00)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order; at least 1 cycle after accept
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  head entry filled; low = bubble
- if_pc  out  XLEN  PC of head entry
- if_instr  out  32  instruction of head entry; NOP_INSTR when if_valid=0

## Operation
- Slot lifecycle: allocated at request accept (stores pc), then filled at response (stores instr), then freed at consume (if_valid && !stall).
- Request issue: imem_req_valid=1 iff (allocated + drop_cnt) < DEPTH, or a slot is freed by consumption this cycle. A slot freed that cycle may be reallocated the same cycle.
- On accept (req_valid && req_ready): fetch_pc <= fetch_pc + 4, wrapping mod 2^XLEN. imem_req_addr holds stable while valid and not ready.
- Response: fills the oldest allocated-unfilled slot. If drop_cnt>0, the response is discarded and drop_cnt decrements.
- Redirect (highest priority, overrides stall):
  - all slots are freed;
  - drop_cnt <= drop_cnt + (allocated-unfilled slots) + (1 if a request is accepted this cycle) − (1 if a response arrives this cycle);
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
- A response arriving in a redirect cycle is discarded. if_valid is 0 the cycle after a redirect.
- Reset mid-operation: all slots freed; drop_cnt=0; fetch_pc=RESET_PC. Memory responses to pre-reset requests are the memory's concern; the memory is reset together with this unit.

## Timing
- Reset values: imem_req_valid=0 while rst low; imem_req_addr=RESET_PC; if_valid=0; if_pc=0; if_instr=NOP_INSTR; drop_cnt=0.
- First request is issued in the first cycle after rst deasserts.
- Response→if_valid latency: 1 cycle (registered fill). Minimum accept→if_valid is 2 cycles with 1-cycle memory.
- Sustained throughput: 1 instruction/cycle with 1-cycle memory, no stall, DEPTH≥2.
- Redirect→new request: same cycle the redirect is seen if capacity allows. The earliest new if_valid is 2 cycles after the redirect address is accepted.
- Stall: head and all outputs hold. Requests continue until capacity is exhausted.

## Configuration
- FETCH_STATS_EN defined: adds outputs stat_fetched (32, count of consumed instructions) and stat_bubble (32, cycles with if_valid=0 and !stall). Both reset to 0, wrap at 2^32, and do not count during redirect cycles.
- FETCH_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- riscv_pkg: NOP_INSTR = 32'h0000_0013; fetch_entry_t struct {pc, instr, filled}.
- Sub-module fetch_queue: a circular buffer of fetch_entry_t with alloc/fill/pop pointers, flush input, and count outputs. fetch_unit holds fetch_pc, drop_cnt and the handshake logic.

## Test plan
- Reset, always-ready 1-cycle memory, no stall → PCs 0x0,0x4,0x8… appear on if_pc on consecutive cycles from cycle 3. if_instr equals memory contents.
- stall held 5 cycles with head at 0x8 → if_pc=0x8 is stable; at most DEPTH requests outstanding; streaming resumes 0xC with no gap or duplicate.
- redirect_pc=0x103 with 2 responses in flight → both are dropped; the next if_pc is 0x100; no instruction from 0x10/0x14 ever has if_valid=1.
- imem_req_ready low for 4 cycles → imem_req_addr stays constant; no PC is skipped.
- Redirect in the same cycle as a response and an accept → the response is discarded, drop_cnt is correct, and the first valid output is the redirect target.
- rst asserted mid-stream → if_valid=0 and imem_req_valid=0 immediately (async); fetch restarts at RESET_PC.
